// File: rtl/interrupt_arbiter_pkg.sv
// interrupt_arbiter_pkg: interrupt cause codes, mip bit positions and arbiter configuration
package interrupt_arbiter_pkg;
    typedef logic [4:0] interrupt_code_t;
    localparam interrupt_code_t M_SOFTWARE_INTERRUPT = 5'd3;
    localparam interrupt_code_t M_TIMER_INTERRUPT = 5'd7;
    localparam interrupt_code_t M_EXTERNAL_INTERRUPT = 5'd11;
    localparam int MIP_MSI_BIT = 3;
    localparam int MIP_MTI_BIT = 7;
    localparam int MIP_MEI_BIT = 11;
    localparam int PLATFORM_INT_BASE = 16;
    localparam int MAX_PLATFORM_INT = 16;
    localparam int NUM_PLATFORM_INT_DEFAULT = 0;
    // Later assignments override earlier ones, so the last hit is the highest priority
    function automatic interrupt_code_t highest_priority(input logic [31:0] en);
        interrupt_code_t code;
        code = '0;
        for (int i = 31; i >= PLATFORM_INT_BASE; i--)
            if (en[i]) code = 5'(i);
        if (en[MIP_MTI_BIT]) code = M_TIMER_INTERRUPT;
        if (en[MIP_MSI_BIT]) code = M_SOFTWARE_INTERRUPT;
        if (en[MIP_MEI_BIT]) code = M_EXTERNAL_INTERRUPT;
        return code;
    endfunction
endpackage

// File: rtl/interrupt_arbiter_if.sv
// interrupt_arbiter_if: raw interrupt lines, CSR enables, mip and the commit request/ack handshake
interface interrupt_arbiter_if #(
    parameter int NUM_PLATFORM_INT = interrupt_arbiter_pkg::NUM_PLATFORM_INT_DEFAULT
);
    localparam int PW = NUM_PLATFORM_INT > 0 ? NUM_PLATFORM_INT : 1;
    logic m_ext_irq;
    logic m_soft_irq;
    logic m_timer_irq;
    logic [PW-1:0] platform_irq;
    logic [31:0] mie;
    logic mstatus_mie;
    logic [31:0] mip;
    logic int_req;
    interrupt_arbiter_pkg::interrupt_code_t int_code;
    logic int_ack;
    modport master (
        input m_ext_irq, m_soft_irq, m_timer_irq, platform_irq, mie, mstatus_mie, int_ack,
        output mip, int_req, int_code
    );
    modport slave (
        output m_ext_irq, m_soft_irq, m_timer_irq, platform_irq, mie, mstatus_mie, int_ack,
        input mip, int_req, int_code
    );
endinterface

// File: rtl/interrupt_arbiter_sync.sv
// irq_synchronizer: multi-flop synchroniser for asynchronous interrupt lines, resets to 0
module irq_synchronizer #(
    parameter int WIDTH = 1,
    parameter int STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    input logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stage_q <= '0;
        else stage_q <= {stage_q[STAGES-2:0], d_i};
    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: synchronises interrupt lines, tracks pending causes and presents
// the highest-priority enabled cause to commit over a req/ack handshake
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int NUM_PLATFORM_INT = NUM_PLATFORM_INT_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    interrupt_arbiter_if.master bus
);
    localparam int PW = NUM_PLATFORM_INT > 0 ? NUM_PLATFORM_INT : 1;
    typedef enum logic [1:0] {IDLE, REQ, TAKEN} int_arb_state_t;
    int_arb_state_t state_q;
    logic int_req_q;
    interrupt_code_t int_code_q;
    logic [PW+2:0] synced;
    logic [PW-1:0] plat_sync, plat_prev_q, plat_pend_q, plat_pend_d, plat_clr, plat_mask;
    logic [31:0] mip, en;
    logic ack_taken;
    irq_synchronizer #(.WIDTH(PW + 3), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst_n(rst_n),
        .d_i({bus.platform_irq, bus.m_timer_irq, bus.m_soft_irq, bus.m_ext_irq}),
        .q_o(synced)
    );
    assign plat_sync = synced[PW+2:3];
    assign plat_mask = NUM_PLATFORM_INT > 0 ? '1 : '0;
    assign ack_taken = state_q == REQ && bus.int_ack;
    always_comb begin
        plat_clr = '0;
        for (int i = 0; i < PW; i++)
            plat_clr[i] = ack_taken && int_code_q == 5'(PLATFORM_INT_BASE + i);
    end
    // A new rising edge on the ack cycle keeps the bit set
    assign plat_pend_d = (plat_sync & ~plat_prev_q | plat_pend_q & ~plat_clr) & plat_mask;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            plat_prev_q <= '0;
            plat_pend_q <= '0;
        end else begin
            plat_prev_q <= plat_sync & plat_mask;
            plat_pend_q <= plat_pend_d;
        end
    always_comb begin
        mip = '0;
        mip[MIP_MEI_BIT] = synced[0];
        mip[MIP_MSI_BIT] = synced[1];
        mip[MIP_MTI_BIT] = synced[2];
        mip[PLATFORM_INT_BASE +: PW] = plat_pend_q;
    end
    assign en = mip & bus.mie & {32{bus.mstatus_mie}};
    // The requested code is frozen in REQ; later arrivals wait for the next IDLE pass
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            int_req_q <= 1'b0;
            int_code_q <= '0;
        end else begin
            case (state_q)
                IDLE:
                    if (|en) begin
                        state_q <= REQ;
                        int_req_q <= 1'b1;
                        int_code_q <= highest_priority(en);
                    end
                REQ:
                    if (bus.int_ack) begin
                        state_q <= TAKEN;
                        int_req_q <= 1'b0;
                    end else if (!en[int_code_q]) begin
                        state_q <= IDLE;
                        int_req_q <= 1'b0;
                    end
                default: state_q <= IDLE;
            endcase
        end
    assign bus.mip = mip;
    assign bus.int_req = int_req_q;
    assign bus.int_code = int_code_q;
endmodule
